dll_acknak_decoder: RTL and testbench

Receive-side DLLP decoder feeding the DLL retry monitor. Takes 6-byte DLLPs from the receive DLLP extractor and checks their CRC-16. Decodes ACK/NAK type and the 12-bit sequence number, then validates it against the outstanding-TLP window. Emits the one-cycle `acknak_seq_en` / `acknak_seq_num` pair consumed by the retry monitor, and suppresses repeated NAKs during a replay hold window.

---
 rtl/dll_acknak_decoder_if.sv | 24 ++
 rtl/dll_acknak_decoder.sv | 183 ++++++++++++++++++
 tb/tb_dll_acknak_decoder.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dll_acknak_decoder_if.sv
// DLLP input / ACK-NAK result bundle between the DLLP extractor, retry monitor and decoder.
// master drives the DLLP and window inputs; slave is the decoder.
interface dll_acknak_decoder_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 dllp_valid_i;
    logic [47:0]          dllp_data_i;
    logic [15:0]          as_i;
    logic [11:0]          next_tx_seq_i;
    logic [1:0]           acknak_seq_en_o;
    logic [15:0]          acknak_seq_num_o;
    logic [CNT_WIDTH-1:0] crc_err_cnt_o;
    logic [CNT_WIDTH-1:0] drop_cnt_o;

    modport master (
        output dllp_valid_i, dllp_data_i, as_i, next_tx_seq_i,
        input  acknak_seq_en_o, acknak_seq_num_o, crc_err_cnt_o, drop_cnt_o
    );

    modport slave (
        input  dllp_valid_i, dllp_data_i, as_i, next_tx_seq_i,
        output acknak_seq_en_o, acknak_seq_num_o, crc_err_cnt_o, drop_cnt_o
    );
endinterface

// File: rtl/dll_acknak_decoder.sv
// ACK/NAK DLLP decoder: CRC-16 check, window validation, repeated-NAK suppression; 2-cycle latency, no backpressure.
// Define DLL_ACKNAK_CRC_CHECK_EN to build the CRC check; otherwise every DLLP is CRC-good and crc_err_cnt_o is 0.
module dll_acknak_decoder #(
    parameter int NAK_HOLD_CYCLES = 255,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 sclk,
    input  logic                 srst,
    dll_acknak_decoder_if.slave  bus
);

    localparam logic [7:0]  TYPE_ACK  = 8'h00;
    localparam logic [7:0]  TYPE_NAK  = 8'h10;
    localparam logic [15:0] HOLD_LOAD = 16'(NAK_HOLD_CYCLES);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    // ---------------- stage 1: capture ----------------
    logic        r_s1_vld;
    logic [7:0]  r_s1_type;
    logic [11:0] r_s1_seq;
    logic        w_crc_ok;
    logic        w_unused;

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= bus.dllp_valid_i;
        end
        r_s1_type <= bus.dllp_data_i[7:0];
        r_s1_seq  <= {bus.dllp_data_i[19:16], bus.dllp_data_i[31:24]};
    end

`ifdef DLL_ACKNAK_CRC_CHECK_EN
    logic [15:0]          r_s1_crc_calc;
    logic [15:0]          r_s1_crc_rx;
    logic [CNT_WIDTH-1:0] r_crc_cnt;

    function automatic logic [7:0] f_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Bit-serial definition: bit 0 of byte 0 enters first, MSB-side feedback.
    function automatic logic [15:0] f_crc16(input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
        end
        return ~c;
    endfunction

    always_ff @(posedge sclk) begin
        r_s1_crc_calc <= f_crc16(bus.dllp_data_i[31:0]);
        r_s1_crc_rx   <= {f_rev8(bus.dllp_data_i[39:32]), f_rev8(bus.dllp_data_i[47:40])};
    end

    assign w_crc_ok = (r_s1_crc_calc == r_s1_crc_rx);

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_crc_cnt <= '0;
        end else if (r_s1_vld && !w_crc_ok && (r_crc_cnt != '1)) begin
            r_crc_cnt <= r_crc_cnt + 1'b1;
        end
    end

    assign bus.crc_err_cnt_o = r_crc_cnt;
    assign w_unused = &{1'b0, bus.as_i[15:12], bus.dllp_data_i[15:8], bus.dllp_data_i[23:20]};
`else
    assign w_crc_ok          = 1'b1;
    assign bus.crc_err_cnt_o = '0;
    assign w_unused = &{1'b0, bus.as_i[15:12], bus.dllp_data_i[15:8], bus.dllp_data_i[23:20],
                        bus.dllp_data_i[47:32]};
`endif

    // ---------------- stage 2: decode, window, hold FSM ----------------
    logic [11:0] w_d;
    logic [11:0] w_w;
    logic [12:0] w_w13;
    logic        w_in_win;
    logic        w_ack_ok;
    logic        w_nak_ok;
    logic        w_is_ack;
    logic        w_is_nak;

    // w == 0 means the whole 4096-entry space is outstanding.
    assign w_d      = r_s1_seq - bus.as_i[11:0];
    assign w_w      = bus.next_tx_seq_i - bus.as_i[11:0];
    assign w_w13    = (w_w == 12'd0) ? 13'd4096 : {1'b0, w_w};
    assign w_in_win = ({1'b0, w_d} < w_w13);
    assign w_ack_ok = w_in_win && (w_d != 12'd0);
    assign w_nak_ok = w_in_win;
    assign w_is_ack = (r_s1_type == TYPE_ACK);
    assign w_is_nak = (r_s1_type == TYPE_NAK);

    state_t               r_state, w_state_nxt;
    logic [11:0]          r_hold_seq, w_hold_seq_nxt;
    logic [15:0]          r_hold_cnt, w_hold_cnt_nxt;
    logic [1:0]           r_en, w_en_nxt;
    logic [15:0]          r_num, w_num_nxt;
    logic [CNT_WIDTH-1:0] r_drop_cnt;
    logic                 w_drop_inc;
    logic                 w_emit;

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_state    <= ST_IDLE;
            r_hold_seq <= '0;
            r_hold_cnt <= '0;
            r_en       <= 2'b00;
            r_num      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_seq <= w_hold_seq_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_en       <= w_en_nxt;
            r_num      <= w_num_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_seq_nxt = r_hold_seq;
        w_hold_cnt_nxt = r_hold_cnt;
        w_en_nxt       = 2'b00;
        w_num_nxt      = '0;
        w_drop_inc     = 1'b0;
        w_emit         = 1'b0;

        if (r_s1_vld && w_crc_ok) begin
            if (w_is_ack) begin
                if (w_ack_ok) begin
                    w_emit      = 1'b1;
                    w_en_nxt    = 2'b01;
                    w_num_nxt   = {4'h0, r_s1_seq};
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_drop_inc = 1'b1;
                end
            end else if (w_is_nak) begin
                if (!w_nak_ok || (r_state == ST_HOLD && r_s1_seq == r_hold_seq)) begin
                    w_drop_inc = 1'b1;
                end else begin
                    w_emit         = 1'b1;
                    w_en_nxt       = 2'b10;
                    w_num_nxt      = {4'h0, r_s1_seq + 12'd1};
                    w_state_nxt    = ST_HOLD;
                    w_hold_seq_nxt = r_s1_seq;
                    w_hold_cnt_nxt = HOLD_LOAD;
                end
            end
        end

        // A suppressed NAK does not pause the hold timer.
        if (r_state == ST_HOLD && !w_emit) begin
            if (r_hold_cnt <= 16'd1) begin
                w_hold_cnt_nxt = '0;
                w_state_nxt    = ST_IDLE;
            end else begin
                w_hold_cnt_nxt = r_hold_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            r_drop_cnt <= '0;
        end else if (w_drop_inc && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.acknak_seq_en_o  = r_en;
    assign bus.acknak_seq_num_o = r_num;
    assign bus.drop_cnt_o       = r_drop_cnt;

endmodule

// File: tb/tb_dll_acknak_decoder.sv
// Directed bench for dll_acknak_decoder: vector table plus hand-written hold, pipeline, reset and saturation sequences.
module tb_dll_acknak_decoder;

`ifdef DLL_ACKNAK_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    localparam logic [7:0] T_ACK = 8'h00;
    localparam logic [7:0] T_NAK = 8'h10;
    localparam logic [7:0] T_OTH = 8'h20;

    logic sclk;
    logic srst;

    dll_acknak_decoder_if #(.CNT_WIDTH(4)) bus ();

    dll_acknak_decoder #(
        .NAK_HOLD_CYCLES (4),
        .CNT_WIDTH       (4)
    ) dut (
        .sclk (sclk),
        .srst (srst),
        .bus  (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [11:0] as_v;
        logic [11:0] nts;
        logic [7:0]  typ;
        logic [11:0] seq;
        bit          bad;
        logic [1:0]  en;
        logic [15:0] num;
        int          dcrc;
        int          ddrop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk_vec(input logic [11:0] a, input logic [11:0] n, input logic [7:0] t,
                                    input logic [11:0] s, input bit b, input logic [1:0] e,
                                    input logic [15:0] m, input int dc, input int dd);
        vec_t v;
        v.as_v = a; v.nts = n; v.typ = t; v.seq = s; v.bad = b;
        v.en = e; v.num = m; v.dcrc = dc; v.ddrop = dd;
        return v;
    endfunction

    function automatic logic [15:0] crc16(input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[15] ^ d[8*k + j];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
            end
        end
        return ~c;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
        return r;
    endfunction

    function automatic logic [47:0] mk_dllp(input logic [7:0] t, input logic [11:0] s, input bit bad);
        logic [31:0] hdr;
        logic [15:0] c;
        logic [47:0] d;
        hdr = {s[7:0], 4'h0, s[11:8], 8'h00, t};
        c   = crc16(hdr);
        d   = {rev8(c[7:0]), rev8(c[15:8]), hdr};
        if (bad) d[40] = ~d[40];
        return d;
    endfunction

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [7:0] t, input logic [11:0] s, input bit bad);
        bus.dllp_valid_i = 1'b1;
        bus.dllp_data_i  = mk_dllp(t, s, bad);
    endtask

    task automatic idle();
        bus.dllp_valid_i = 1'b0;
        bus.dllp_data_i  = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [1:0] en, input logic [15:0] num);
        chk({name, "_en"},  {30'd0, bus.acknak_seq_en_o}, {30'd0, en});
        chk({name, "_num"}, {16'd0, bus.acknak_seq_num_o}, {16'd0, num});
    endtask

    int exp_crc;
    int exp_drop;

    initial begin
        srst              = 1'b1;
        bus.as_i          = 16'd10;
        bus.next_tx_seq_i = 12'd20;
        idle();
        exp_crc  = 0;
        exp_drop = 0;

        // Reset state
        repeat (3) tick();
        chk_out("reset", 2'b00, 16'd0);
        chk("reset_crc",  {28'd0, bus.crc_err_cnt_o}, 32'd0);
        chk("reset_drop", {28'd0, bus.drop_cnt_o}, 32'd0);
        srst = 1'b0;
        tick();

        // Vector table (expected counter deltas are accumulated below)
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_ACK, 12'd15,   0, 2'b01, 16'd15, 0, 0));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_ACK, 12'd15,   1, CRC_EN ? 2'b00 : 2'b01,
                              CRC_EN ? 16'd0 : 16'd15, CRC_EN ? 1 : 0, 0));
        vecs.push_back(mk_vec(12'd4090, 12'd5,   T_ACK, 12'd2,    0, 2'b01, 16'd2,   0, 0));
        vecs.push_back(mk_vec(12'd4090, 12'd5,   T_ACK, 12'd6,    0, 2'b00, 16'd0,   0, 1));
        vecs.push_back(mk_vec(12'd4090, 12'd5,   T_NAK, 12'd4095, 0, 2'b10, 16'd0,   0, 0));
        vecs.push_back(mk_vec(12'd4090, 12'd5,   T_ACK, 12'd4090, 0, 2'b00, 16'd0,   0, 1));
        vecs.push_back(mk_vec(12'd100,  12'd100, T_ACK, 12'd99,   0, 2'b01, 16'd99,  0, 0));
        vecs.push_back(mk_vec(12'd100,  12'd100, T_NAK, 12'd99,   0, 2'b10, 16'd100, 0, 0));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_ACK, 12'd19,   0, 2'b01, 16'd19,  0, 0));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_ACK, 12'd20,   0, 2'b00, 16'd0,   0, 1));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_NAK, 12'd10,   0, 2'b10, 16'd11,  0, 0));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_NAK, 12'd9,    0, 2'b00, 16'd0,   0, 1));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_OTH, 12'd15,   0, 2'b00, 16'd0,   0, 0));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_OTH, 12'd15,   1, 2'b00, 16'd0, CRC_EN ? 1 : 0, 0));
        vecs.push_back(mk_vec(12'd10,   12'd20,  T_NAK, 12'd19,   1, CRC_EN ? 2'b00 : 2'b10,
                              CRC_EN ? 16'd0 : 16'd20, CRC_EN ? 1 : 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.as_i          = {4'h0, vecs[i].as_v};
            bus.next_tx_seq_i = vecs[i].nts;
            send(vecs[i].typ, vecs[i].seq, vecs[i].bad);
            tick();
            idle();
            tick();
            exp_crc  += vecs[i].dcrc;
            exp_drop += vecs[i].ddrop;
            chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].num);
            chk($sformatf("vec%0d_crc", i),  {28'd0, bus.crc_err_cnt_o}, exp_crc);
            chk($sformatf("vec%0d_drop", i), {28'd0, bus.drop_cnt_o}, exp_drop);
            tick();
            chk($sformatf("vec%0d_pulse", i), {30'd0, bus.acknak_seq_en_o}, 32'd0);
            repeat (6) tick();
        end

        // NAK hold window: repeat suppressed, then re-emitted after expiry
        bus.as_i          = 16'd10;
        bus.next_tx_seq_i = 12'd20;
        send(T_NAK, 12'd12, 0);
        tick();
        send(T_NAK, 12'd12, 0);
        tick();
        chk_out("hold_first", 2'b10, 16'd13);
        idle();
        tick();
        exp_drop += 1;
        chk_out("hold_supp", 2'b00, 16'd0);
        chk("hold_supp_drop", {28'd0, bus.drop_cnt_o}, exp_drop);
        repeat (7) tick();
        send(T_NAK, 12'd12, 0);
        tick();
        idle();
        tick();
        chk_out("hold_expired", 2'b10, 16'd13);
        chk("hold_expired_drop", {28'd0, bus.drop_cnt_o}, exp_drop);
        repeat (6) tick();

        // Different NAK reloads, ACK leaves HOLD, same NAK after ACK is new
        send(T_NAK, 12'd14, 0);
        tick();
        send(T_ACK, 12'd16, 0);
        tick();
        chk_out("reload_nak14", 2'b10, 16'd15);
        send(T_NAK, 12'd14, 0);
        tick();
        chk_out("reload_ack16", 2'b01, 16'd16);
        send(T_NAK, 12'd15, 0);
        tick();
        chk_out("reload_nak14b", 2'b10, 16'd15);
        send(T_NAK, 12'd15, 0);
        tick();
        chk_out("reload_nak15", 2'b10, 16'd16);
        idle();
        tick();
        exp_drop += 1;
        chk_out("reload_supp15", 2'b00, 16'd0);
        chk("reload_drop", {28'd0, bus.drop_cnt_o}, exp_drop);
        repeat (8) tick();

        // Back-to-back throughput
        send(T_ACK, 12'd11, 0);
        tick();
        send(T_ACK, 12'd12, 0);
        tick();
        chk_out("b2b_ack11", 2'b01, 16'd11);
        send(T_OTH, 12'd15, 0);
        tick();
        chk_out("b2b_ack12", 2'b01, 16'd12);
        send(T_ACK, 12'd10, 0);
        tick();
        chk_out("b2b_other", 2'b00, 16'd0);
        idle();
        tick();
        exp_drop += 1;
        chk_out("b2b_dup", 2'b00, 16'd0);
        chk("b2b_drop", {28'd0, bus.drop_cnt_o}, exp_drop);
        repeat (3) tick();

        // Reset with a DLLP in flight and another presented during reset
        send(T_ACK, 12'd15, 0);
        tick();
        srst = 1'b1;
        tick();
        chk_out("rst_flight", 2'b00, 16'd0);
        chk("rst_crc",  {28'd0, bus.crc_err_cnt_o}, 32'd0);
        chk("rst_drop", {28'd0, bus.drop_cnt_o}, 32'd0);
        srst = 1'b0;
        send(T_ACK, 12'd17, 0);
        tick();
        chk_out("rst_discard", 2'b00, 16'd0);
        idle();
        tick();
        chk_out("rst_first", 2'b01, 16'd17);
        repeat (2) tick();

        // Counter saturation at all-ones (4-bit counters)
        for (int i = 0; i < 17; i++) begin
            send(T_ACK, 12'd10, 0);
            tick();
        end
        idle();
        repeat (2) tick();
        chk("sat_drop", {28'd0, bus.drop_cnt_o}, 32'd15);
        for (int i = 0; i < 17; i++) begin
            send(T_OTH, 12'd3, 1);
            tick();
        end
        idle();
        repeat (2) tick();
        chk("sat_crc", {28'd0, bus.crc_err_cnt_o}, CRC_EN ? 32'd15 : 32'd0);
        chk("sat_drop_hold", {28'd0, bus.drop_cnt_o}, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
